// File: rtl/peripheral_uart_if.sv
// peripheral_uart_if
//   PU-side peripheral bus for the UART.
//   enabled            : pipeline advance qualifier from the PU
//   peripheral_op      : peripheral operation present (condition met)
//   peripheral_write   : 1 = push byte to TX, 0 = pop byte from RX
//   peripheral_out     : byte written by the PU
//   peripheral_in      : RX FIFO head byte, 8'h00 when RX is empty
//   peripheral_success : result of the current operation
//
// Handshake: an operation is offered when enabled & peripheral_op are both
// high in a cycle. peripheral_success answers combinationally in that same
// cycle (1 = accepted, 0 = refused). An accepted write or read takes effect
// at the next clock edge. A refused operation changes nothing and is not
// retried by the peripheral; the PU sees it as N = ~success.
interface peripheral_uart_if;
  logic       enabled;
  logic       peripheral_op;
  logic       peripheral_write;
  logic [7:0] peripheral_out;
  logic [7:0] peripheral_in;
  logic       peripheral_success;

  modport master (
    output enabled, peripheral_op, peripheral_write, peripheral_out,
    input  peripheral_in, peripheral_success
  );

  modport slave (
    input  enabled, peripheral_op, peripheral_write, peripheral_out,
    output peripheral_in, peripheral_success
  );
endinterface

// File: rtl/peripheral_uart.sv
// peripheral_uart
//   8N1 UART with TX and RX FIFOs, attached to the PU peripheral bus.
// Ports:
//   clock, reset  : single clock, synchronous active-high reset
//   bus           : PU peripheral bus (slave side)
//   uart_tx       : serial transmit line, idle high, registered
//   uart_rx       : asynchronous serial receive line, idle high
//   rx_overflow   : sticky, a received byte was dropped because RX was full
//   tx_state      : debug view of the TX FSM (0 IDLE, 1 START, 2 DATA, 3 STOP)
//   rx_state      : debug view of the RX FSM (same encoding)
//   tx_count      : debug view of the TX FIFO fill level
//   rx_count      : debug view of the RX FIFO fill level
module peripheral_uart #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  peripheral_uart_if.slave            bus,
  output logic                        uart_tx,
  input  logic                        uart_rx,
  output logic                        rx_overflow,
  output logic [1:0]                  tx_state,
  output logic [1:0]                  rx_state,
  output logic [$clog2(FIFO_DEPTH):0] tx_count,
  output logic [$clog2(FIFO_DEPTH):0] rx_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  // The falling edge is seen one cycle before START is entered, so the
  // mid-start sample lands at count HALF-1 of the START state.
  localparam logic [15:0]   BAUD_MID = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  // ---------------------------------------------------------------------
  // PU bus decode
  // ---------------------------------------------------------------------
  logic accepted;
  logic tx_push;
  logic rx_pop;

  assign accepted = bus.enabled & bus.peripheral_op & ~reset;
  assign tx_push  = accepted &  bus.peripheral_write & (tx_count < DEPTH_C);
  assign rx_pop   = accepted & ~bus.peripheral_write & (rx_count != '0);
  assign bus.peripheral_success = tx_push | rx_pop;

  // ---------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wr_ptr;
  logic [PW-1:0] tx_rd_ptr;
  logic          tx_pop;

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.peripheral_out;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // ---------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------
  uart_state_t tx_st, tx_st_n;
  logic [15:0] tx_baud, tx_baud_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_st    <= ST_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      tx_st    <= tx_st_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
    end
  end

  always_comb begin
    tx_st_n    = tx_st;
    tx_baud_n  = tx_baud + 16'd1;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    case (tx_st)
      ST_IDLE: begin
        tx_baud_n = '0;
        if (tx_count != '0) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_mem[tx_rd_ptr];
          tx_st_n    = ST_START;
        end
      end
      ST_START: begin
        if (tx_baud == BAUD_MAX) begin
          tx_baud_n = '0;
          tx_bit_n  = '0;
          tx_st_n   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_baud == BAUD_MAX) begin
          tx_baud_n = '0;
          if (tx_bit == 3'd7) begin
            tx_st_n = ST_STOP;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (tx_baud == BAUD_MAX) begin
          tx_baud_n = '0;
          // Chain straight into the next frame so no idle bit is inserted.
          if (tx_count != '0) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_mem[tx_rd_ptr];
            tx_st_n    = ST_START;
          end else begin
            tx_st_n = ST_IDLE;
          end
        end
      end
      default: tx_st_n = ST_IDLE;
    endcase

    // The line level is derived from the next state so the register holds
    // exactly what the FSM will be sending during the coming cycle.
    case (tx_st_n)
      ST_START: tx_line_n = 1'b0;
      ST_DATA:  tx_line_n = tx_shift_n[0];
      default:  tx_line_n = 1'b1;
    endcase
  end

  assign tx_state = tx_st;

  // ---------------------------------------------------------------------
  // RX synchronizer and edge detect
  // ---------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // ---------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr_ptr;
  logic [PW-1:0] rx_rd_ptr;
  logic          rx_push;
  logic          rx_ovf_set;
  logic [7:0]    rx_shift, rx_shift_n;

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      rx_overflow <= 1'b0;
    end else begin
      if (rx_push)    rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)     rx_rd_ptr <= rx_rd_ptr + 1'b1;
      if (rx_ovf_set) rx_overflow <= 1'b1;
      rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
    end
  end

  assign bus.peripheral_in = (rx_count != '0 && !reset) ? rx_mem[rx_rd_ptr] : 8'h00;

  // ---------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------
  uart_state_t rx_st, rx_st_n;
  logic [15:0] rx_baud, rx_baud_n;
  logic [2:0]  rx_bit, rx_bit_n;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_st    <= ST_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_st    <= rx_st_n;
      rx_baud  <= rx_baud_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_st_n    = rx_st;
    rx_baud_n  = rx_baud + 16'd1;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_push    = 1'b0;
    rx_ovf_set = 1'b0;
    case (rx_st)
      ST_IDLE: begin
        rx_baud_n = '0;
        if (rx_d && !rx_s2) rx_st_n = ST_START;
      end
      ST_START: begin
        if (rx_baud == BAUD_MID) begin
          rx_baud_n = '0;
          rx_bit_n  = '0;
          // A start bit that is high again at mid-bit was only a glitch.
          rx_st_n   = rx_s2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_baud == BAUD_MAX) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_st_n = ST_STOP;
          else                rx_bit_n = rx_bit + 3'd1;
        end
      end
      ST_STOP: begin
        if (rx_baud == BAUD_MAX) begin
          rx_baud_n = '0;
          rx_st_n   = ST_IDLE;
          // A low stop bit is a framing error: the byte is dropped silently.
          if (rx_s2) begin
            if (rx_count != DEPTH_C) rx_push    = 1'b1;
            else                     rx_ovf_set = 1'b1;
          end
        end
      end
      default: rx_st_n = ST_IDLE;
    endcase
  end

  assign rx_state = rx_st;

endmodule

// File: tb/tb_peripheral_uart.sv
// tb_peripheral_uart
//   Directed bench for peripheral_uart with CLKS_PER_BIT=4, FIFO_DEPTH=8.
//   Inputs are driven 1 time unit after the rising edge and outputs are
//   sampled there too, away from the active edge.
module tb_peripheral_uart;
  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uart_tx;
  logic       uart_rx = 1'b1;
  logic       rx_overflow;
  logic [1:0] tx_state;
  logic [1:0] rx_state;
  logic [3:0] tx_count;
  logic [3:0] rx_count;

  always #5 clock = ~clock;

  peripheral_uart_if bus ();

  peripheral_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .uart_tx     (uart_tx),
    .uart_rx     (uart_rx),
    .rx_overflow (rx_overflow),
    .tx_state    (tx_state),
    .rx_state    (rx_state),
    .tx_count    (tx_count),
    .rx_count    (rx_count)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic en, input logic op, input logic wr, input logic [7:0] d);
    bus.enabled          = en;
    bus.peripheral_op    = op;
    bus.peripheral_write = wr;
    bus.peripheral_out   = d;
    #1;
  endtask

  task automatic idle_bus();
    bus.enabled          = 1'b0;
    bus.peripheral_op    = 1'b0;
    bus.peripheral_write = 1'b0;
    bus.peripheral_out   = 8'h00;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) tick();
    end
    uart_rx = stop_bit;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    repeat (CPB) tick();
  endtask

  // Decodes one frame off uart_tx; ok is 0 on timeout or bad start/stop.
  task automatic get_tx_frame(output logic [7:0] b, output logic ok);
    int n;
    b  = 8'h00;
    ok = 1'b0;
    n  = 0;
    tick();
    while (uart_tx !== 1'b0 && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) return;
    tick();
    tick();
    ok = (uart_tx == 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) tick();
      b[i] = uart_tx;
    end
    repeat (CPB) tick();
    ok = ok & (uart_tx == 1'b1);
  endtask

  // ---------------- stimulus tables ----------------
  logic [7:0] wdata [9] = '{8'h01, 8'h80, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h3C, 8'hC3, 8'h99};
  logic       wres  [9];
  logic [7:0] fgot  [9];
  logic       fok   [9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    logic [9:0] frame;
    logic [7:0] eb;
    int         lows;
    int         n;
    logic       seen;

    idle_bus();

    // ---- reset state, operation during reset ----
    repeat (3) tick();
    drive_op(1'b1, 1'b1, 1'b1, 8'hAB);
    check("rst_success", bus.peripheral_success, 1'b0);
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_pin", bus.peripheral_in, 8'h00);
    check("rst_ovf", rx_overflow, 1'b0);
    check("rst_rx_count", rx_count, 4'd0);
    tick();
    check("rst_tx_count", tx_count, 4'd0);
    idle_bus();
    reset = 1'b0;
    tick();

    // ---- single TX frame 8'hA5 ----
    drive_op(1'b1, 1'b1, 1'b1, 8'hA5);
    check("a5_success", bus.peripheral_success, 1'b1);
    tick();
    idle_bus();
    check("a5_pre_line", uart_tx, 1'b1);
    check("a5_tx_count", tx_count, 4'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 40; k++) begin
      tick();
      check($sformatf("a5_bit%0d_c%0d", k / 4, k % 4), uart_tx, frame[k / 4]);
    end
    tick();
    check("a5_idle_state", tx_state, 2'd0);
    check("a5_idle_line", uart_tx, 1'b1);

    // ---- TX FIFO full: busy frame then 9 writes ----
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 8; i++) exp_q.push_back(wdata[i]);
    fork
      begin
        drive_op(1'b1, 1'b1, 1'b1, 8'hFF);
        tick();
        idle_bus();
        tick();
        for (int i = 0; i < 9; i++) begin
          drive_op(1'b1, 1'b1, 1'b1, wdata[i]);
          wres[i] = bus.peripheral_success;
          tick();
        end
        idle_bus();
      end
      begin
        for (int f = 0; f < 9; f++) get_tx_frame(fgot[f], fok[f]);
      end
    join
    for (int i = 0; i < 9; i++)
      check($sformatf("full_wr%0d_success", i), wres[i], (i < 8) ? 1'b1 : 1'b0);
    for (int f = 0; f < 9; f++) begin
      eb = exp_q.pop_front();
      check($sformatf("full_frame%0d", f), fgot[f], eb);
      check($sformatf("full_frame%0d_ok", f), fok[f], 1'b1);
    end
    lows = 0;
    repeat (60) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("full_no_extra_frame", lows, 0);
    check("full_tx_count", tx_count, 4'd0);

    // ---- RX single frame 8'h3C ----
    send_rx(8'h3C, 1'b1);
    check("rx3c_pin", bus.peripheral_in, 8'h3C);
    check("rx3c_count", rx_count, 4'd1);
    drive_op(1'b1, 1'b1, 1'b0, 8'h00);
    check("rx3c_rd_success", bus.peripheral_success, 1'b1);
    tick();
    idle_bus();
    check("rx3c_pin_after", bus.peripheral_in, 8'h00);
    drive_op(1'b1, 1'b1, 1'b0, 8'h00);
    check("rx3c_rd2_success", bus.peripheral_success, 1'b0);
    tick();
    idle_bus();
    check("rx3c_count_after", rx_count, 4'd0);

    // ---- framing error, then overflow ----
    send_rx(8'h77, 1'b0);
    check("frm_count", rx_count, 4'd0);
    check("frm_ovf", rx_overflow, 1'b0);
    for (int i = 0; i < 9; i++) send_rx(8'h40 + 8'(i), 1'b1);
    check("ovf_flag", rx_overflow, 1'b1);
    check("ovf_count", rx_count, 4'd8);
    for (int i = 0; i < 8; i++) begin
      drive_op(1'b1, 1'b1, 1'b0, 8'h00);
      check($sformatf("ovf_head%0d", i), bus.peripheral_in, 8'h40 + 8'(i));
      check($sformatf("ovf_rd%0d_success", i), bus.peripheral_success, 1'b1);
      tick();
    end
    idle_bus();
    check("ovf_drained", rx_count, 4'd0);
    check("ovf_pin_empty", bus.peripheral_in, 8'h00);
    check("ovf_sticky", rx_overflow, 1'b1);

    // ---- enabled low write, RX glitch ----
    drive_op(1'b0, 1'b1, 1'b1, 8'h5A);
    check("dis_success", bus.peripheral_success, 1'b0);
    tick();
    idle_bus();
    check("dis_tx_count", tx_count, 4'd0);
    lows = 0;
    repeat (12) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("dis_line_high", lows, 0);
    uart_rx = 1'b0;
    tick();
    tick();
    uart_rx = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (rx_state == 2'd1) seen = 1'b1;
    end
    check("glitch_start_seen", seen, 1'b1);
    check("glitch_rx_idle", rx_state, 2'd0);
    check("glitch_rx_count", rx_count, 4'd0);

    // ---- reset mid TX frame with 3 bytes queued ----
    drive_op(1'b1, 1'b1, 1'b1, 8'h12); tick();
    drive_op(1'b1, 1'b1, 1'b1, 8'h34); tick();
    drive_op(1'b1, 1'b1, 1'b1, 8'h56); tick();
    drive_op(1'b1, 1'b1, 1'b1, 8'h78); tick();
    idle_bus();
    n = 0;
    while (tx_state !== 2'd2 && n < 100) begin
      tick();
      n++;
    end
    check("mid_data_reached", (n < 100), 1'b1);
    repeat (12) tick();
    check("mid_bit3_line", uart_tx, 1'b0);
    check("mid_tx_count", tx_count, 4'd3);
    reset = 1'b1;
    drive_op(1'b1, 1'b1, 1'b1, 8'h9A);
    check("mid_rst_success", bus.peripheral_success, 1'b0);
    tick();
    idle_bus();
    check("mid_rst_line", uart_tx, 1'b1);
    check("mid_rst_tx_count", tx_count, 4'd0);
    check("mid_rst_state", tx_state, 2'd0);
    check("mid_rst_ovf", rx_overflow, 1'b0);
    check("mid_rst_pin", bus.peripheral_in, 8'h00);
    reset = 1'b0;
    lows = 0;
    repeat (100) begin
      tick();
      if (uart_tx !== 1'b1) lows++;
    end
    check("mid_no_frames", lows, 0);
    check("mid_tx_count_end", tx_count, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/peripheral_uart.md
PERIPHERAL_UART -- requirements
Module: peripheral_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 4..65535).
REQ-002 Parameter FIFO_DEPTH, default 8, entries per TX and RX FIFO (power of two).
REQ-003 clock  in  1  single clock; all state updates on posedge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enabled  in  1  PU pipeline advance qualifier; a PU operation is accepted only in a cycle where this is high.
REQ-006 peripheral_op  in  1  PU stage-5 peripheral operation with its condition met.
REQ-007 peripheral_write  in  1  1 = push byte to TX, 0 = pop byte from RX; qualified by peripheral_op.
REQ-008 peripheral_out  in  8  byte written by the PU.
REQ-009 peripheral_in  out  8  RX FIFO head byte; 8'h00 when RX is empty.
REQ-010 peripheral_success  out  1  combinational result of the current operation, consumed as the PU N flag (N = ~success).
REQ-011 uart_tx  out  1  serial transmit line, idle high.
REQ-012 uart_rx  in  1  asynchronous serial receive line, idle high.
REQ-013 rx_overflow  out  1  sticky flag: a received byte was dropped.

Function
REQ-014 Accepted operation = enabled & peripheral_op; no FIFO state changes on an operation when enabled is low.
REQ-015 Write: peripheral_success = TX count < FIFO_DEPTH, using the count before this cycle's updates; on success, push peripheral_out at the next edge; on failure, drop the byte.
REQ-016 Read: peripheral_success = RX count != 0, using the count before this cycle's updates; on success, pop the head at the next edge; on failure, no change.
REQ-017 peripheral_success = 0 when no accepted operation is present.
REQ-018 TX and RX FIFOs: circular, pointers wrap modulo FIFO_DEPTH, count width log2(FIFO_DEPTH)+1; a simultaneous push and pop in the same cycle leaves the count unchanged.
REQ-019 TX FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..CLKS_PER_BIT-1 and restarts on every state entry.
REQ-020 IDLE: uart_tx = 1; when TX is non-empty, pop the head into the shift register and go to START at the next edge.
REQ-021 START: uart_tx = 0 for CLKS_PER_BIT cycles, then DATA.
REQ-022 DATA: send 8 bits LSB first, each for CLKS_PER_BIT cycles, then STOP.
REQ-023 STOP: uart_tx = 1 for CLKS_PER_BIT cycles, then IDLE; back-to-back frames add no extra idle cycle.
REQ-024 uart_tx is driven from a flop, never combinationally.
REQ-025 RX path: uart_rx passes through a 2-flop synchronizer before any use.
REQ-026 RX FSM states: IDLE, START, DATA, STOP.
REQ-027 RX IDLE -> START on a synchronized falling edge.
REQ-028 RX START: resample at CLKS_PER_BIT/2; if high, treat as a glitch and return to IDLE; otherwise sample 8 data bits at full-bit intervals from mid-start.
REQ-029 RX STOP: sample the stop bit at mid-bit. If 1, push the byte if RX is not full; if RX is full, drop the byte and set rx_overflow. If 0 (framing error), discard the byte silently. Then IDLE.
REQ-030 An RX push completing in the same cycle as a successful read is legal, and the count is unchanged; RX push does not depend on enabled.
REQ-031 peripheral_in reflects the new head in the cycle after a pop or a push into an empty FIFO.

Reset
REQ-032 Reset clears both FIFOs (pointers and counts 0) and rx_overflow (0), forces both FSMs to IDLE, and clears the synchronizer flops to 1.
REQ-033 During and after reset, uart_tx = 1, peripheral_in = 8'h00, peripheral_success = 0.
REQ-034 Reset mid-frame aborts the frame immediately: uart_tx = 1 on the next cycle, and the partial RX byte is discarded.
REQ-035 Operations presented while reset is high have no effect and report success 0.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-036 Write 8'hA5 -> success=1; uart_tx shows 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles, starting 1 cycle after the push.
REQ-037 Hold TX busy, 9 writes in consecutive enabled cycles -> first 8 report success 1, 9th reports 0; exactly 8 frames emerge, in order.
REQ-038 Drive frame 8'h3C on uart_rx -> after the stop mid-sample, peripheral_in=8'h3C; read -> success=1, then peripheral_in=8'h00; second read -> success=0.
REQ-039 Receive 9 frames with no reads -> rx_overflow=1, FIFO holds the first 8 bytes; a frame with stop bit 0 adds no entry.
REQ-040 Write with enabled=0 -> no push, uart_tx stays 1; 2-cycle low pulse on uart_rx -> RX returns to IDLE with no push.
REQ-041 Assert reset at TX DATA bit 3 with 3 bytes queued -> uart_tx=1 the next cycle, TX count 0, no further frames.
